// File: rtl/joy_pkg.sv
// joy_pkg: joystick conditioning types, direction bit indices and arbitration helpers
package joy_pkg;
  typedef enum logic [1:0] {JM_8WAY, JM_4LAST, JM_4FIRST, JM_2H} joy_mode_e;
  localparam int D_UP = 3;
  localparam int D_DOWN = 2;
  localparam int D_LEFT = 1;
  localparam int D_RIGHT = 0;
  function automatic logic [3:0] prio_sel(input logic [3:0] v);
    return v[D_UP] ? 4'(1 << D_UP) : v[D_DOWN] ? 4'(1 << D_DOWN) : v[D_LEFT] ? 4'(1 << D_LEFT) : v[D_RIGHT] ? 4'(1 << D_RIGHT) : 4'b0000;
  endfunction
  function automatic logic [3:0] socd(input logic [3:0] v);
    return {(&v[D_UP:D_DOWN]) ? 2'b00 : v[D_UP:D_DOWN], (&v[D_LEFT:D_RIGHT]) ? 2'b00 : v[D_LEFT:D_RIGHT]};
  endfunction
endpackage

// File: rtl/joy_chan.sv
// joy_chan: one joystick channel - sync, debounce, direction-mode arbitration and autofire
module joy_chan
  import joy_pkg::*;
#(
  parameter int DEB_LEN = 4,
  parameter int AF_BITS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [1:0]         mode,
  input  logic [3:0]         in_dir,
  input  logic               in_fire,
  input  logic               af_en,
  input  logic [AF_BITS-1:0] af_half,
  output logic [3:0]         out_dir,
  output logic               out_fire,
  output logic               dir_chg
);
  localparam int CW = (DEB_LEN > 0) ? $clog2(DEB_LEN + 1) : 1;
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_LEN);
  logic [4:0] s1_q, s2_q, acc_q, acc_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [3:0] prev_q, eff, new_dir, kept, mask_q, mask_d, out_dir_q, out_dir_d;
  logic [1:0] mode_q;
  joy_mode_e m;
  logic mode_chg, dir_chg_q, dir_chg_d;
  logic af_act, af_wrap, af_ph_q, af_ph_d, out_fire_q, out_fire_d;
  logic [AF_BITS-1:0] af_cnt_q, af_cnt_d;
  // bit 4 is fire; a bit is accepted once it has differed from the accepted value for DEB_LEN ticks
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      acc_d[i] = (s2_q[i] != acc_q[i] && cnt_q[i] == DEB_MAX) ? s2_q[i] : acc_q[i];
      cnt_d[i] = (s2_q[i] == acc_q[i] || cnt_q[i] == DEB_MAX) ? '0 : ce ? cnt_q[i] + CW'(1) : cnt_q[i];
    end
  end
  // releases drop the mask before new edges are considered, so a new press always wins in 4-last mode
  always_comb begin
    m = joy_mode_e'(mode);
    mode_chg = mode != mode_q;
    eff = (m == JM_2H) ? (acc_q[3:0] & 4'b0011) : acc_q[3:0];
    new_dir = eff & ~prev_q;
    kept = mask_q & eff;
    mask_d = (mode_chg || m == JM_8WAY) ? 4'b0000
           : (m != JM_4FIRST && |new_dir) ? prio_sel(new_dir)
           : (|kept) ? mask_q : prio_sel(eff);
    out_dir_d = (m == JM_8WAY) ? socd(acc_q[3:0]) : mask_d;
    dir_chg_d = |(out_dir_d ^ out_dir_q);
  end
  always_comb begin
    af_act = af_en && (af_half != '0) && acc_q[4];
    af_wrap = af_cnt_q >= af_half - AF_BITS'(1);
    af_cnt_d = !af_act ? '0 : !ce ? af_cnt_q : af_wrap ? '0 : af_cnt_q + AF_BITS'(1);
    af_ph_d = af_act && (af_ph_q ^ (ce && af_wrap));
    out_fire_d = af_act ? ~af_ph_q : acc_q[4];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      prev_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      out_dir_q <= '0;
      dir_chg_q <= 1'b0;
      af_cnt_q <= '0;
      af_ph_q <= 1'b0;
      out_fire_q <= 1'b0;
    end else begin
      s1_q <= {in_fire, in_dir};
      s2_q <= s1_q;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      prev_q <= acc_q[3:0];
      mask_q <= mask_d;
      mode_q <= mode;
      out_dir_q <= out_dir_d;
      dir_chg_q <= dir_chg_d;
      af_cnt_q <= af_cnt_d;
      af_ph_q <= af_ph_d;
      out_fire_q <= out_fire_d;
    end
  end
  assign out_dir = out_dir_q;
  assign out_fire = out_fire_q;
  assign dir_chg = dir_chg_q;
endmodule

// File: rtl/joy_dir_arbiter.sv
// joy_dir_arbiter: N-channel joystick conditioner sharing tick enable and autofire period
module joy_dir_arbiter
  import joy_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEB_LEN  = 4,
  parameter int AF_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [4*CHANNELS-1:0] in_dir,
  input  logic [CHANNELS-1:0]   in_fire,
  input  logic [CHANNELS-1:0]   af_en,
  input  logic [AF_BITS-1:0]    af_half,
  output logic [4*CHANNELS-1:0] out_dir,
  output logic [CHANNELS-1:0]   out_fire,
  output logic [CHANNELS-1:0]   dir_chg
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    joy_chan #(
      .DEB_LEN(DEB_LEN),
      .AF_BITS(AF_BITS)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .mode    (mode[2*c +: 2]),
      .in_dir  (in_dir[4*c +: 4]),
      .in_fire (in_fire[c]),
      .af_en   (af_en[c]),
      .af_half (af_half),
      .out_dir (out_dir[4*c +: 4]),
      .out_fire(out_fire[c]),
      .dir_chg (dir_chg[c])
    );
  end
endmodule

// File: tb/tb_joy_dir_arbiter.sv
// tb_joy_dir_arbiter: directed scoreboard bench for the two-channel joystick conditioner
module tb_joy_dir_arbiter;
  localparam int LAT = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  logic [3:0] mode;
  logic [7:0] in_dir;
  logic [1:0] in_fire, af_en;
  logic [7:0] af_half;
  logic [7:0] out_dir;
  logic [1:0] out_fire, dir_chg;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int         due;
    string      tag;
    logic [7:0] dir;
    logic [1:0] fire;
    logic [1:0] chg;
  } exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  joy_dir_arbiter #(.CHANNELS(2), .DEB_LEN(4), .AF_BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .mode    (mode),
    .in_dir  (in_dir),
    .in_fire (in_fire),
    .af_en   (af_en),
    .af_half (af_half),
    .out_dir (out_dir),
    .out_fire(out_fire),
    .dir_chg (dir_chg)
  );
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      assert (e.due == cyc && out_dir === e.dir && out_fire === e.fire && dir_chg === e.chg)
      else begin
        failures++;
        $error("FAIL %s cyc=%0d due=%0d dir=%h exp=%h fire=%b exp=%b chg=%b exp=%b",
               e.tag, cyc, e.due, out_dir, e.dir, out_fire, e.fire, dir_chg, e.chg);
      end
    end
  end
  task automatic push(input int due, input string tag, input logic [7:0] d, input logic [1:0] f, input logic [1:0] c);
    exp_t x;
    x.due = due;
    x.tag = tag;
    x.dir = d;
    x.fire = f;
    x.chg = c;
    q.push_back(x);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    checks++;
    assert (q.size() == 0)
    else begin
      failures++;
      $error("FAIL drain pending=%0d required=0", q.size());
    end
  endtask
  // hold inputs for 10 clk; output must show the new value (and a dir_chg pulse) exactly LAT clk later, for one clk
  task automatic step(input string tag, input logic [7:0] d, input logic [1:0] f,
                      input logic [7:0] ed, input logic [1:0] ef, input logic [1:0] ec);
    push(cyc + LAT, tag, ed, ef, ec);
    push(cyc + LAT + 1, {tag, "_hold"}, ed, ef, 2'b00);
    in_dir = d;
    in_fire = f;
    tick(10);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int t;
    mode = 4'b0000;
    in_dir = 8'h00;
    in_fire = 2'b00;
    af_en = 2'b00;
    af_half = 8'd0;
    tick(3);
    push(cyc, "reset", 8'h00, 2'b00, 2'b00);
    tick(1);
    reset_n = 1'b1;
    tick(2);
    t = cyc;
    push(t + LAT, "glitch_a", 8'h00, 2'b00, 2'b00);
    push(t + LAT + 2, "glitch_b", 8'h00, 2'b00, 2'b00);
    in_dir = 8'h01;
    tick(3);
    in_dir = 8'h00;
    drain();
    tick(6);
    t = cyc;
    push(t + LAT - 1, "hold_pre", 8'h00, 2'b00, 2'b00);
    push(t + LAT, "hold_on", 8'h01, 2'b00, 2'b01);
    push(t + LAT + 1, "hold_once", 8'h01, 2'b00, 2'b00);
    push(t + LAT + 5, "hold_off_pre", 8'h01, 2'b00, 2'b00);
    push(t + LAT + 6, "hold_off", 8'h00, 2'b00, 2'b01);
    in_dir = 8'h01;
    tick(6);
    in_dir = 8'h00;
    drain();
    tick(4);
    mode = 4'b0001;
    tick(2);
    step("m1_up", 8'h08, 2'b00, 8'h08, 2'b00, 2'b01);
    step("m1_add_left", 8'h0A, 2'b00, 8'h02, 2'b00, 2'b01);
    step("m1_rel_left", 8'h08, 2'b00, 8'h08, 2'b00, 2'b01);
    step("m1_rel", 8'h00, 2'b00, 8'h00, 2'b00, 2'b01);
    drain();
    mode = 4'b0010;
    tick(2);
    step("m2_up", 8'h08, 2'b00, 8'h08, 2'b00, 2'b01);
    step("m2_add_left", 8'h0A, 2'b00, 8'h08, 2'b00, 2'b00);
    step("m2_rel_up", 8'h02, 2'b00, 8'h02, 2'b00, 2'b01);
    step("m2_rel", 8'h00, 2'b00, 8'h00, 2'b00, 2'b01);
    drain();
    mode = 4'b0000;
    tick(2);
    step("m0_socd_ud", 8'h0D, 2'b00, 8'h01, 2'b00, 2'b01);
    step("m0_socd_lr", 8'h0B, 2'b00, 8'h08, 2'b00, 2'b01);
    step("m0_rel", 8'h00, 2'b00, 8'h00, 2'b00, 2'b01);
    drain();
    mode = 4'b0011;
    tick(2);
    step("m3_ch1_m0", 8'h4A, 2'b00, 8'h42, 2'b00, 2'b11);
    step("m3_rel", 8'h00, 2'b00, 8'h00, 2'b00, 2'b11);
    drain();
    mode = 4'b0001;
    tick(2);
    step("sw_right", 8'h01, 2'b00, 8'h01, 2'b00, 2'b01);
    step("sw_to_up", 8'h08, 2'b00, 8'h08, 2'b00, 2'b01);
    step("m1_prio", 8'h05, 2'b00, 8'h04, 2'b00, 2'b01);
    step("sw_rel", 8'h00, 2'b00, 8'h00, 2'b00, 2'b01);
    step("fire_plain", 8'h00, 2'b10, 8'h00, 2'b10, 2'b00);
    step("fire_rel", 8'h00, 2'b00, 8'h00, 2'b00, 2'b00);
    drain();
    af_en = 2'b01;
    af_half = 8'd3;
    tick(2);
    t = cyc;
    for (int i = 0; i < 12; i++) push(t + LAT + i, "af3", 8'h00, {1'b0, (i % 6) < 3}, 2'b00);
    push(t + LAT + 12, "af3_rel", 8'h00, 2'b00, 2'b00);
    in_fire = 2'b01;
    tick(12);
    in_fire = 2'b00;
    drain();
    tick(6);
    af_half = 8'd0;
    tick(2);
    t = cyc;
    for (int i = 0; i < 6; i++) push(t + LAT + i, "af0", 8'h00, 2'b01, 2'b00);
    push(t + LAT + 16, "af0_rel", 8'h00, 2'b00, 2'b00);
    in_fire = 2'b01;
    tick(16);
    in_fire = 2'b00;
    drain();
    tick(6);
    af_half = 8'd3;
    mode = 4'b1000;
    tick(2);
    t = cyc;
    push(t + LAT, "rb_on", 8'h81, 2'b01, 2'b11);
    for (int i = 1; i < 4; i++) push(t + LAT + i, "rb_af", 8'h81, {1'b0, i < 3}, 2'b00);
    in_dir = 8'h81;
    in_fire = 2'b01;
    tick(LAT + 4);
    reset_n = 1'b0;
    push(cyc, "rst_async", 8'h00, 2'b00, 2'b00);
    tick(2);
    reset_n = 1'b1;
    t = cyc;
    push(t + LAT - 1, "rr_pre", 8'h00, 2'b00, 2'b00);
    push(t + LAT, "rr_on", 8'h81, 2'b01, 2'b11);
    push(t + LAT + 3, "rr_af", 8'h81, 2'b00, 2'b00);
    tick(LAT + 6);
    in_dir = 8'h00;
    in_fire = 2'b00;
    drain();
    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/joy_dir_arbiter.md
# joy_dir_arbiter

Multi-channel joystick conditioning block placed between the HPS/DB15/keyboard input merge and the core's active-low input ports. Each channel synchronises and debounces raw direction and fire bits, then applies a per-channel direction mode (8-way, 4-way last-pressed, 4-way first-pressed, 2-way horizontal) and optional autofire. It generalises the single-purpose 4-way one-direction filter to N channels with selectable behaviour.

## Interface
- CHANNELS, 2, number of independent player channels (1..4)
- DEB_LEN, 4, ce ticks a synchronised bit must be stable before acceptance; 0 = bypass
- AF_BITS, 8, width of autofire half-period counter

- clk  in  1  system clock (clk_sys domain)
- reset_n  in  1  asynchronous, active-low reset; one clock domain only
- ce  in  1  sample/tick enable for debounce and autofire counters
- mode  in  2*CHANNELS  per-channel mode: 0 8-way, 1 4-way last-pressed, 2 4-way first-pressed, 3 2-way horizontal
- in_dir  in  4*CHANNELS  raw active-high {up,down,left,right} per channel, channel 0 in LSBs
- in_fire  in  CHANNELS  raw active-high fire
- af_en  in  CHANNELS  autofire enable per channel
- af_half  in  AF_BITS  autofire half-period in ce ticks; 0 = autofire off
- out_dir  out  4*CHANNELS  conditioned directions, registered
- out_fire  out  CHANNELS  conditioned fire, registered
- dir_chg  out  CHANNELS  one-clk pulse when out_dir of that channel changes

## Operation
- Sync: every input bit through 2 flops; mode and af_half are quasi-static, no sync.
- Debounce: per bit, counter reloads on change of synced value; accepted value updates when counter reaches DEB_LEN ce ticks of stability.
- Edge detect on accepted directions: new = acc & ~acc_prev.
- Mode 0: out = acc, except up+down both set -> both 0, left+right both set -> both 0 (SOCD neutral).
- Mode 1: any new direction loads one-hot mask; simultaneous new edges priority up>down>left>right. When masked direction released, mask reloads to highest-priority still-held direction, else 0. out = acc & mask.
- Mode 2: mask loads only when mask is 0 (priority as above); held until that direction released, then reloads from held set.
- Mode 3: up/down forced 0; left/right arbitrated as mode 1.
- Mode change on a channel: mask cleared that cycle, re-evaluated next cycle from held set.
- Autofire: af_en=1 and af_half!=0 and fire accepted -> out_fire=1 immediately, counter counts ce ticks, toggles out_fire every af_half ticks. Release -> out_fire=0, counter=0. Otherwise out_fire = accepted fire.
- dir_chg = |(out_dir_next ^ out_dir) registered with out_dir.

## Timing
- Reset: all flops, masks, counters 0; out_dir, out_fire, dir_chg = 0.
- Latency raw -> out: 2 clk sync + DEB_LEN ce ticks + 1 clk accept + 1 clk output register; DEB_LEN=0 gives 4 clk.
- Autofire counter saturating-free: wraps compare at af_half-1 -> 0; af_half change mid-burst takes effect at next compare.
- Press and release of different directions in same cycle: release processed first, then new edge wins.
- reset_n deassertion mid-press: channel starts with mask 0, held direction re-acquired within one clk after acceptance (mode 2 included).

## Structure
- Package joy_pkg: mode enum (JM_8WAY, JM_4LAST, JM_4FIRST, JM_2H), direction bit indices (D_UP=3..D_RIGHT=0), priority-select function.
- Sub-module joy_chan: one channel (sync, debounce, mode arbiter, autofire); top instantiates CHANNELS copies via generate and shares ce/af_half.

## Test plan
- DEB_LEN=4, ce every clk, glitch in_dir right for 3 clk -> out_dir stays 0; hold 6 clk -> out_dir=0001 at clk 8, dir_chg pulse once.
- Mode 1: hold up, then add left -> out 0010; release left -> out 1000 next accepted cycle.
- Mode 2: hold up, add left -> out stays 1000; release up -> out 0010.
- Mode 0: up+down+right held -> out 0001; mode 3 with up+left -> out 0010.
- af_half=3, ce every clk, hold fire 12 clk -> out_fire 1,1,1,0,0,0,1... ; release -> 0 next output cycle; af_half=0 -> steady 1.
- Assert reset_n low mid-autofire burst -> all outputs 0 asynchronously; release with inputs held -> outputs reappear after debounce latency.
